word_check_scheduler: RTL and testbench

Round-robin scheduler that shares one 3-bit "all-ones" word checker among NREQ requesters. Each granted word is evaluated MSB first over a fixed 3-cycle frame, one bit per cycle. A one-cycle error pulse is raised, tagged with the source requester, when all three bits are 1. The block sits in front of the per-word monitoring logic and owns a saturating error counter for the whole group.

---
 rtl/word_check_scheduler_if.sv | 26 ++
 rtl/word_check_scheduler.sv | 122 ++++++++++++
 tb/tb_word_check_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/word_check_scheduler_if.sv
// Bundle of requester-side and result-side signals of the shared word checker.
// The scheduler takes the slave modport; the requester group and monitor take master.
interface word_check_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 8
);
    logic [NREQ-1:0]   req;
    logic [3*NREQ-1:0] din;
    logic              clr_cnt;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              err;
    logic [ID_W-1:0]   err_id;
    logic [CNT_W-1:0]  err_cnt;

    modport master (
        output req, din, clr_cnt,
        input  grant, busy, err, err_id, err_cnt
    );

    modport slave (
        input  req, din, clr_cnt,
        output grant, busy, err, err_id, err_cnt
    );
endinterface

// File: rtl/word_check_scheduler.sv
// Round-robin scheduler feeding one 3-bit all-ones checker; each word occupies a
// fixed 3-cycle frame (B2, B1, B0) and yields a tagged one-cycle err pulse.
module word_check_scheduler #(
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    word_check_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B2   = 2'd1,
        B1   = 2'd2,
        B0   = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic              decision;
    logic              busy;
    logic [2:0]        word_arr [NREQ];
    logic              found;
    logic [ID_W-1:0]   win_idx;
    int                scan_idx;

    logic [2:0]        word_reg;
    logic [ID_W-1:0]   id_reg;
    logic [ID_W-1:0]   last_reg;
    logic              pass_reg;
    logic [NREQ-1:0]   grant_reg;
    logic              err_reg;
    logic [ID_W-1:0]   err_id_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              err_next;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign word_arr[gi] = bus.din[3*gi +: 3];
        end
    endgenerate

    // Scan from farthest to nearest so the requester right after last wins.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        scan_idx = 0;
        for (int k = NREQ; k >= 1; k--) begin
            scan_idx = int'(last_reg) + k;
            if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
            if (bus.req[scan_idx]) begin
                found   = 1'b1;
                win_idx = ID_W'(scan_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        case (state_reg)
            IDLE, B0: state_next = found ? B2 : IDLE;
            B2:       state_next = B1;
            B1:       state_next = B0;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        decision = (state_reg == IDLE) || (state_reg == B0);
        busy     = (state_reg != IDLE);
    end

    assign err_next = (state_reg == B0) && pass_reg && word_reg[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_reg   <= '0;
            id_reg     <= '0;
            last_reg   <= ID_W'(NREQ - 1);
            pass_reg   <= 1'b0;
            grant_reg  <= '0;
            err_reg    <= 1'b0;
            err_id_reg <= '0;
        end else begin
            grant_reg <= '0;
            err_reg   <= err_next;
            if (err_next) err_id_reg <= id_reg;
            if (decision) begin
                pass_reg <= 1'b0;
                if (found) begin
                    word_reg  <= word_arr[win_idx];
                    id_reg    <= win_idx;
                    last_reg  <= win_idx;
                    grant_reg <= NREQ'(1) << win_idx;
                end
            end else if (state_reg == B2) begin
                pass_reg <= word_reg[2];
            end else begin
                pass_reg <= pass_reg & word_reg[1];
            end
        end
    end

    // Clear wins over a coincident increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                            cnt_reg <= '0;
        else if (bus.clr_cnt)                cnt_reg <= '0;
        else if (err_next && cnt_reg != '1)  cnt_reg <= cnt_reg + CNT_W'(1);
    end

    assign bus.grant   = grant_reg;
    assign bus.busy    = busy;
    assign bus.err     = err_reg;
    assign bus.err_id  = err_id_reg;
    assign bus.err_cnt = cnt_reg;
endmodule

// File: tb/tb_word_check_scheduler.sv
// Bench for word_check_scheduler: a frame-level reference model driven by cycle
// numbers, plus a second instance with a 2-bit counter for saturation.
module tb_word_check_scheduler;
    localparam int NREQ   = 4;
    localparam int ID_W   = 2;
    localparam int CNT_W  = 8;
    localparam int CNT2_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [3*NREQ-1:0] din = '0;
    logic              clr_cnt = 1'b0;
    int                checks = 0;
    int                failures = 0;

    word_check_scheduler_if #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W))  bus ();
    word_check_scheduler_if #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT2_W)) bus2 ();

    assign bus.req      = req;
    assign bus.din      = din;
    assign bus.clr_cnt  = clr_cnt;
    assign bus2.req     = req;
    assign bus2.din     = din;
    assign bus2.clr_cnt = clr_cnt;

    word_check_scheduler #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));
    word_check_scheduler #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT2_W)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus2.slave));

    always #5 clk = ~clk;

    // Reference model: a frame starts at decision cycle fstart, its verdict lands
    // on edge fstart+3, and the next decision happens on that same edge.
    logic [NREQ-1:0] exp_grant;
    logic            exp_busy, exp_err;
    logic [ID_W-1:0] exp_err_id;
    int              exp_cnt, exp_cnt2;
    int              cyc, fstart, fid, mlast, mw;
    logic [2:0]      fword;

    always begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            cyc = 0; fstart = -1; fid = 0; mlast = NREQ - 1; fword = '0;
            exp_grant = '0; exp_busy = 1'b0; exp_err = 1'b0; exp_err_id = '0;
            exp_cnt = 0; exp_cnt2 = 0;
        end else begin
            cyc = cyc + 1;
            exp_err = (fstart >= 0) && (cyc == fstart + 3) && (fword == 3'b111);
            if (fstart >= 0 && cyc == fstart + 3)
                $display("frame id=%0d word=%b err=%0d cyc=%0d", fid, fword, exp_err, cyc);
            if (exp_err) exp_err_id = fid[ID_W-1:0];
            if (clr_cnt) begin
                exp_cnt = 0; exp_cnt2 = 0;
            end else if (exp_err) begin
                if (exp_cnt  < (1 << CNT_W)  - 1) exp_cnt  = exp_cnt + 1;
                if (exp_cnt2 < (1 << CNT2_W) - 1) exp_cnt2 = exp_cnt2 + 1;
            end
            exp_grant = '0;
            if (fstart < 0 || cyc >= fstart + 3) begin
                fstart = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    mw = (mlast + k) % NREQ;
                    if (fstart < 0 && req[mw]) begin
                        fstart = cyc; fid = mw; mlast = mw;
                        fword = din[3*mw +: 3];
                        exp_grant[mw] = 1'b1;
                    end
                end
            end
            exp_busy = (fstart >= 0) && (cyc < fstart + 3);
        end
    end

    localparam int VW = 2 * (NREQ + 2 + ID_W) + CNT_W + CNT2_W;
    logic [VW-1:0] obs_vec, exp_vec;
    assign obs_vec = {bus.grant, bus.busy, bus.err, bus.err_id, bus.err_cnt,
                      bus2.grant, bus2.busy, bus2.err, bus2.err_id, bus2.err_cnt};
    assign exp_vec = {exp_grant, exp_busy, exp_err, exp_err_id, exp_cnt[CNT_W-1:0],
                      exp_grant, exp_busy, exp_err, exp_err_id, exp_cnt2[CNT2_W-1:0]};

    task automatic pulse_reset;
        @(negedge clk);
        rst = 1'b0; req = '0; din = '0; clr_cnt = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs_vec !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h expected=0", obs_vec);
        end
        rst = 1'b1;
    endtask

    task automatic test_single;
        pulse_reset();
        din = NREQ*3'($urandom); din[2:0] = 3'b111; req = 4'b0001;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL single c=%0d got=%h expected=%h", c, obs_vec, exp_vec);
            end
            if (c == 1) begin
                checks++;
                if (bus.grant !== 4'b0001) begin
                    failures++;
                    $display("FAIL single_grant got=%b expected=0001", bus.grant);
                end
                req = '0; din = 12'($urandom);
            end
            if (c == 4) begin
                checks++;
                if ({bus.err, bus.err_id, bus.err_cnt} !== {1'b1, 2'd0, 8'd1}) begin
                    failures++;
                    $display("FAIL single_err got=%b/%0d/%0d expected=1/0/1",
                             bus.err, bus.err_id, bus.err_cnt);
                end
            end
        end
    endtask

    task automatic test_early_zero;
        logic [2:0] words [3];
        words[0] = 3'b011; words[1] = 3'b101; words[2] = 3'b110;
        pulse_reset();
        for (int w = 0; w < 3; w++) begin
            din = 12'($urandom); din[8:6] = words[w]; req = 4'b0100;
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                checks++;
                if (obs_vec !== exp_vec) begin
                    failures++;
                    $display("FAIL early_zero w=%b c=%0d got=%h expected=%h",
                             words[w], c, obs_vec, exp_vec);
                end
                if (c == 1) req = '0;
                if (c == 4) begin
                    checks++;
                    if (bus.err !== 1'b0 || bus.err_cnt !== 8'd0) begin
                        failures++;
                        $display("FAIL early_zero_err w=%b got err=%b cnt=%0d expected err=0 cnt=0",
                                 words[w], bus.err, bus.err_cnt);
                    end
                end
            end
        end
    endtask

    task automatic test_round_robin;
        logic [NREQ-1:0] seq [5];
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        pulse_reset();
        req = '1; din = '1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL round_robin c=%0d got=%h expected=%h", c, obs_vec, exp_vec);
            end
            if (c % 3 == 1 && c <= 13) begin
                checks++;
                if (bus.grant !== seq[c/3]) begin
                    failures++;
                    $display("FAIL rr_grant c=%0d got=%b expected=%b", c, bus.grant, seq[c/3]);
                end
            end
            if (c == 13) req = '0;
        end
        checks++;
        if (bus.err_cnt !== 8'd5 || bus.err_id !== 2'd0) begin
            failures++;
            $display("FAIL rr_count got cnt=%0d id=%0d expected cnt=5 id=0", bus.err_cnt, bus.err_id);
        end
    endtask

    task automatic test_saturation;
        bit done;
        pulse_reset();
        req = '1; din = '1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL saturation c=%0d got=%h expected=%h", c, obs_vec, exp_vec);
            end
        end
        checks++;
        if (bus2.err_cnt !== 2'd3) begin
            failures++;
            $display("FAIL sat_value got=%0d expected=3", bus2.err_cnt);
        end
        done = 1'b0;
        for (int c = 0; c < 6 && !done; c++) begin
            if (fstart >= 0 && cyc == fstart + 2) begin
                clr_cnt = 1'b1;
                @(negedge clk);
                clr_cnt = 1'b0;
                done = 1'b1;
                checks++;
                if (bus.err !== 1'b1 || bus.err_cnt !== 8'd0 || bus2.err_cnt !== 2'd0) begin
                    failures++;
                    $display("FAIL clr_with_err got err=%b cnt=%0d cnt2=%0d expected err=1 cnt=0 cnt2=0",
                             bus.err, bus.err_cnt, bus2.err_cnt);
                end
            end else begin
                @(negedge clk);
            end
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL sat_clear c=%0d got=%h expected=%h", c, obs_vec, exp_vec);
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL sat_clear_window got=none expected=B0 cycle");
        end
        req = '0;
    endtask

    task automatic test_reset_mid_frame;
        pulse_reset();
        req = '1; din = '1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.err, bus.err_cnt} !== 10'd0 || obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL reset_mid got busy=%b err=%b cnt=%0d expected 0/0/0",
                     bus.busy, bus.err, bus.err_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL reset_mid_after c=%0d got=%h expected=%h", c, obs_vec, exp_vec);
            end
            if (c == 1) begin
                checks++;
                if (bus.grant !== 4'b0001) begin
                    failures++;
                    $display("FAIL reset_mid_grant got=%b expected=0001", bus.grant);
                end
            end
        end
        req = '0;
    endtask

    task automatic test_idle_gap;
        pulse_reset();
        req = 4'b0001; din = '1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL idle_gap c=%0d got=%h expected=%h", c, obs_vec, exp_vec);
            end
            if (c == 3) req = '0;
            if (c == 5) begin
                checks++;
                if (bus.busy !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_busy got=%b expected=0", bus.busy);
                end
            end
            if (c == 6) begin req = 4'b1000; din = 12'($urandom); end
            if (c == 7) begin
                checks++;
                if (bus.grant !== 4'b1000) begin
                    failures++;
                    $display("FAIL idle_grant got=%b expected=1000", bus.grant);
                end
            end
            if (c == 9) req = '1;
            if (c == 10) begin
                checks++;
                if (bus.grant !== 4'b0001) begin
                    failures++;
                    $display("FAIL idle_pointer got=%b expected=0001", bus.grant);
                end
            end
        end
        req = '0;
    endtask

    task automatic test_random;
        pulse_reset();
        for (int c = 1; c <= 400; c++) begin
            req = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++)
                din[3*i +: 3] = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'($urandom);
            clr_cnt = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL random c=%0d got=%h expected=%h", c, obs_vec, exp_vec);
            end
        end
        req = '0; clr_cnt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_early_zero();
        test_round_robin();
        test_saturation();
        test_reset_mid_frame();
        test_idle_gap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
